tdm_demux4: RTL

- Receive-side counterpart of the team's 4:1 channel mux.
- Takes a time-division-multiplexed word stream (one channel per beat, slot 0 marked by start-of-frame) and distributes it back onto four parallel channel outputs.
- Captures complete frames only and presents them atomically with a one-cycle valid strobe.
- Detects framing errors and resynchronises.

---
 rtl/tdm_pkg.sv | 22 ++
 rtl/tdm_demux4_dec2to4.sv | 24 ++
 rtl/tdm_demux4.sv | 109 ++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM frame receive path.
// Slot indices are 2-bit and wrap naturally from 3 back to 0.
package tdm_pkg;

    localparam int SLOT_W = 2;
    localparam int NSLOT  = 4;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SLOT_W-1:0] SLOT0 = 2'd0;
    localparam logic [SLOT_W-1:0] SLOT1 = 2'd1;
    localparam logic [SLOT_W-1:0] SLOT2 = 2'd2;
    localparam logic [SLOT_W-1:0] SLOT3 = 2'd3;

    function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
        return SLOT_W'(s + 1'b1);
    endfunction

endpackage

// File: rtl/tdm_demux4_dec2to4.sv
// 2-to-4 one-hot decoder of a slot index, gated by an enable.
// Drives the per-slot write strobes of the frame receiver.
module dec2to4
    import tdm_pkg::*;
(
    input  logic [SLOT_W-1:0] sel,
    input  logic              en,
    output logic [NSLOT-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            case (sel)
                SLOT0:   onehot = 4'b0001;
                SLOT1:   onehot = 4'b0010;
                SLOT2:   onehot = 4'b0100;
                SLOT3:   onehot = 4'b1000;
                default: onehot = '0;
            endcase
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Receive-side TDM demultiplexer: collects four-slot frames into shadow
// registers and presents complete frames atomically with a one-cycle strobe.
//
// state | meaning
// HUNT  | not framed; waiting for a beat carrying start-of-frame
// RUN   | framed; slot tracks the position of the next accepted beat
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NSLOT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_sof,
    output logic [WIDTH-1:0]  out_ch0,
    output logic [WIDTH-1:0]  out_ch1,
    output logic [WIDTH-1:0]  out_ch2,
    output logic [WIDTH-1:0]  out_ch3,
    output logic              out_valid,
    output logic              out_err,
    output logic [SLOT_W-1:0] slot,
    output logic              locked
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);

    state_t                    state;
    logic [WIDTH-1:0]          shadow0;
    logic [WIDTH-1:0]          shadow1;
    logic [WIDTH-1:0]          shadow2;
    logic [SLOT_W-1:0]         wr_sel;
    logic                      wr_en;
    logic [tdm_pkg::NSLOT-1:0] wr_hot;
    logic                      frame_done;

    // A beat with SOF always restarts at slot 0, whatever slot we expected;
    // a beat without SOF at slot 0 is a framing error and writes nothing.
    assign wr_sel = in_sof ? SLOT0 : slot;
    assign wr_en  = in_valid && (in_sof || (state == RUN && slot != SLOT0));

    dec2to4 u_dec (
        .sel    (wr_sel),
        .en     (wr_en),
        .onehot (wr_hot)
    );

    // The last slot bypasses the shadows and goes straight to out_ch3.
    assign frame_done = wr_hot[LAST_SLOT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            slot      <= SLOT0;
            locked    <= 1'b0;
            shadow0   <= '0;
            shadow1   <= '0;
            shadow2   <= '0;
            out_ch0   <= '0;
            out_ch1   <= '0;
            out_ch2   <= '0;
            out_ch3   <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;

            if (wr_hot[0]) shadow0 <= in_data;
            if (wr_hot[1]) shadow1 <= in_data;
            if (wr_hot[2]) shadow2 <= in_data;

            if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (in_sof) begin
                            state  <= RUN;
                            locked <= 1'b1;
                            slot   <= SLOT1;
                        end
                    end
                    RUN: begin
                        if (in_sof) begin
                            out_err <= (slot != SLOT0);
                            slot    <= SLOT1;
                        end else if (slot == SLOT0) begin
                            out_err <= 1'b1;
                            state   <= HUNT;
                            locked  <= 1'b0;
                            slot    <= SLOT0;
                        end else if (frame_done) begin
                            out_ch0   <= shadow0;
                            out_ch1   <= shadow1;
                            out_ch2   <= shadow2;
                            out_ch3   <= in_data;
                            out_valid <= 1'b1;
                            slot      <= SLOT0;
                        end else begin
                            slot <= slot_inc(slot);
                        end
                    end
                endcase
            end
        end
    end

endmodule
